// File: rtl/mvu_pkg.sv
// mvu_pkg: shared MVU types and constants.
// Contents:
//   APB_ADDR_WIDTH / APB_DATA_WIDTH - default APB bus widths. paddr[AW-1:12]
//                                     selects an MVU and paddr[11:0] selects a CSR.
//   APB_REQ_TIMEOUT                 - default ACCESS wait limit for the APB requester.
//   apb_req_t                       - one queued APB command {write, addr, wdata}.
//   apb_req_state_t                 - APB requester FSM state encoding.
package mvu_pkg;

  localparam int APB_ADDR_WIDTH  = 16;
  localparam int APB_DATA_WIDTH  = 32;
  localparam int APB_REQ_TIMEOUT = 255;

  typedef struct packed {
    logic                      write;
    logic [APB_ADDR_WIDTH-1:0] addr;
    logic [APB_DATA_WIDTH-1:0] wdata;
  } apb_req_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_req_state_t;

endpackage

// File: rtl/mvu_apb_cfg_requester_if.sv
// mvu_apb_cfg_requester_if: APB bus bundle between the configuration
// requester and the MVU APB completer.
// Signals:
//   psel, penable, pwrite, paddr, pwdata - driven by the requester (master).
//   prdata, pready, pslverr               - driven by the completer (slave).
interface mvu_apb_cfg_requester_if #(
  parameter int AW = mvu_pkg::APB_ADDR_WIDTH,
  parameter int DW = 32
);

  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata;
  logic          pready;
  logic          pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/mvu_apb_cmd_fifo.sv
// mvu_apb_cmd_fifo: synchronous command FIFO for the APB requester.
// Ports:
//   clk, rst    - clock and synchronous active-high reset (flushes the FIFO).
//   push, din   - write din when push is high and the FIFO is not full.
//   pop, dout   - dout is the current head; pop advances it when not empty.
//   full, empty - occupancy flags, both derived from registered pointers.
module mvu_apb_cmd_fifo
  import mvu_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = apb_req_t
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  T     din,
  output T     dout,
  output logic full,
  output logic empty
);

  localparam int PW = $clog2(DEPTH);

  T            mem_q [DEPTH];
  T            mem_d [DEPTH];
  logic [PW:0] wr_ptr_q, wr_ptr_d;
  logic [PW:0] rd_ptr_q, rd_ptr_d;

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                 (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign dout  = mem_q[rd_ptr_q[PW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push && !full) begin
      mem_d[wr_ptr_q[PW-1:0]] = din;
      wr_ptr_d                = wr_ptr_q + 1'b1;
    end
    if (pop && !empty) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // Storage is not reset; only the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
    mem_q <= mem_d;
  end

endmodule

// File: rtl/mvu_apb_cfg_requester.sv
// mvu_apb_cfg_requester: queues {write, addr, data} commands and runs them as
// APB SETUP/ACCESS transfers toward the MVU CSR completer, returning one
// response per command in order.
// Ports:
//   clk, rst                         - clock, synchronous active-high reset.
//   cmd_valid/cmd_ready, cmd_write,
//   cmd_addr, cmd_wdata              - command push side (ready = FIFO not full).
//   rsp_valid/rsp_ready, rsp_rdata,
//   rsp_err, rsp_timeout             - response side, held stable until consumed.
//   busy                             - FIFO non-empty or a transfer in progress.
//   psel, penable, pwrite, paddr,
//   pwdata, prdata, pready, pslverr  - flat APB master signals; a parent binds
//                                      them to mvu_apb_cfg_requester_if.
module mvu_apb_cfg_requester
  import mvu_pkg::*;
#(
  parameter int AW      = APB_ADDR_WIDTH,
  parameter int DW      = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = APB_REQ_TIMEOUT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic          rsp_timeout,
  output logic          busy,
  output logic          psel,
  output logic          penable,
  output logic          pwrite,
  output logic [AW-1:0] paddr,
  output logic [DW-1:0] pwdata,
  input  logic [DW-1:0] prdata,
  input  logic          pready,
  input  logic          pslverr
);

  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_SETUP  = SETUP;
  localparam logic [1:0] ST_ACCESS = ACCESS;
  localparam logic [1:0] ST_RESP   = RESP;

  // Timer value seen in the last allowed ACCESS cycle before aborting.
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  // Same layout as apb_req_t, sized to this instance's bus widths.
  typedef struct packed {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  logic [1:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [AW-1:0] paddr_q, paddr_d;
  logic [DW-1:0] pwdata_q, pwdata_d;
  logic          pwrite_q, pwrite_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          err_q, err_d;
  logic          timeout_q, timeout_d;

  req_t fifo_din;
  req_t fifo_head;
  logic fifo_push;
  logic fifo_pop;
  logic fifo_full;
  logic fifo_empty;

  assign fifo_din  = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
  assign fifo_push = cmd_valid && !fifo_full;

  mvu_apb_cmd_fifo #(
    .DEPTH (DEPTH),
    .T     (req_t)
  ) u_cmd_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Response fields are rewritten only when an ACCESS phase ends, so they stay
  // stable for the whole RESP phase regardless of the bus.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    pwrite_d  = pwrite_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    timeout_d = timeout_q;
    fifo_pop  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          paddr_d  = fifo_head.addr;
          pwdata_d = fifo_head.wdata;
          pwrite_d = fifo_head.write;
          state_d  = ST_SETUP;
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (pready) begin
          rdata_d   = pwrite_q ? '0 : prdata;
          err_d     = pslverr;
          timeout_d = 1'b0;
          timer_d   = '0;
          state_d   = ST_RESP;
        end else if (timer_q == TIMER_LAST) begin
          rdata_d   = '0;
          err_d     = 1'b1;
          timeout_d = 1'b1;
          timer_d   = '0;
          state_d   = ST_RESP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pwrite_q  <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pwrite_q  <= pwrite_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      timeout_q <= timeout_d;
    end
  end

  // APB strobes decode straight from the registered state, so a timeout
  // (ACCESS -> RESP) drops psel/penable in the same cycle rsp_valid rises.
  assign psel        = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
  assign penable     = (state_q == ST_ACCESS);
  assign pwrite      = pwrite_q;
  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;
  assign rsp_valid   = (state_q == ST_RESP);
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = err_q;
  assign rsp_timeout = timeout_q;
  assign cmd_ready   = !fifo_full;
  assign busy        = !fifo_empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_mvu_apb_cfg_requester.sv
// tb_mvu_apb_cfg_requester: directed self-checking bench for the APB
// configuration requester. A small completer model answers on the bus:
// prdata = {16'hC0DE, paddr} unless overridden, pslverr only at 0x3000.
`timescale 1ns/1ps
module tb_mvu_apb_cfg_requester;

  localparam int AW      = 16;
  localparam int DW      = 32;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 8;

  logic clk = 1'b0;
  logic rst;

  logic          cmdValid;
  logic          cmdReady;
  logic          cmdWrite;
  logic [AW-1:0] cmdAddr;
  logic [DW-1:0] cmdWdata;
  logic          rspValid;
  logic          rspReady;
  logic [DW-1:0] rspRdata;
  logic          rspErr;
  logic          rspTimeout;
  logic          busy;

  logic          preadyDrv;
  logic          rdataOverrideEn;
  logic [DW-1:0] rdataOverride;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mvu_apb_cfg_requester_if #(.AW(AW), .DW(DW)) apb ();

  // Completer model
  assign apb.pready  = preadyDrv;
  assign apb.prdata  = rdataOverrideEn ? rdataOverride : {16'hC0DE, apb.paddr};
  assign apb.pslverr = (apb.paddr == 16'h3000);

  mvu_apb_cfg_requester #(
    .AW      (AW),
    .DW      (DW),
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmdValid),
    .cmd_ready   (cmdReady),
    .cmd_write   (cmdWrite),
    .cmd_addr    (cmdAddr),
    .cmd_wdata   (cmdWdata),
    .rsp_valid   (rspValid),
    .rsp_ready   (rspReady),
    .rsp_rdata   (rspRdata),
    .rsp_err     (rspErr),
    .rsp_timeout (rspTimeout),
    .busy        (busy),
    .psel        (apb.psel),
    .penable     (apb.penable),
    .pwrite      (apb.pwrite),
    .paddr       (apb.paddr),
    .pwdata      (apb.pwdata),
    .prdata      (apb.prdata),
    .pready      (apb.pready),
    .pslverr     (apb.pslverr)
  );

  // Advance one clock and settle just after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Offer one command for exactly one cycle.
  task automatic applyStimulus(input logic w, input logic [AW-1:0] a,
                               input logic [DW-1:0] d);
    cmdValid = 1'b1;
    cmdWrite = w;
    cmdAddr  = a;
    cmdWdata = d;
    tick();
    cmdValid = 1'b0;
  endtask

  // Wait a bounded number of cycles for rsp_valid; expiry counts as a failure.
  task automatic waitRsp(input string tag, input int budget);
    int n = 0;
    while (!rspValid && n < budget) begin
      tick();
      n++;
    end
    checkOutput({tag, "_rsp_seen"}, 64'(rspValid), 64'd1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int extra;
    rst             = 1'b1;
    cmdValid        = 1'b0;
    cmdWrite        = 1'b0;
    cmdAddr         = '0;
    cmdWdata        = '0;
    rspReady        = 1'b0;
    preadyDrv       = 1'b1;
    rdataOverrideEn = 1'b0;
    rdataOverride   = '0;
    repeat (3) tick();

    // Reset state
    checkOutput("rst_psel",      64'(apb.psel),    64'd0);
    checkOutput("rst_penable",   64'(apb.penable), 64'd0);
    checkOutput("rst_pwrite",    64'(apb.pwrite),  64'd0);
    checkOutput("rst_paddr",     64'(apb.paddr),   64'd0);
    checkOutput("rst_pwdata",    64'(apb.pwdata),  64'd0);
    checkOutput("rst_rsp_valid", 64'(rspValid),    64'd0);
    checkOutput("rst_rsp_rdata", 64'(rspRdata),    64'd0);
    checkOutput("rst_rsp_err",   64'(rspErr),      64'd0);
    checkOutput("rst_rsp_to",    64'(rspTimeout),  64'd0);
    checkOutput("rst_busy",      64'(busy),        64'd0);
    checkOutput("rst_cmd_ready", 64'(cmdReady),    64'd1);
    rst = 1'b0;

    // Single write, zero wait states: SETUP at cycle 2, ACCESS at 3, RESP at 4
    $display("[TB] single write");
    applyStimulus(1'b1, 16'h1040, 32'hDEAD_BEEF);
    checkOutput("wr_c1_psel",    64'(apb.psel),    64'd0);
    checkOutput("wr_c1_busy",    64'(busy),        64'd1);
    tick();
    checkOutput("wr_c2_psel",    64'(apb.psel),    64'd1);
    checkOutput("wr_c2_penable", 64'(apb.penable), 64'd0);
    tick();
    checkOutput("wr_c3_psel",    64'(apb.psel),    64'd1);
    checkOutput("wr_c3_penable", 64'(apb.penable), 64'd1);
    checkOutput("wr_c3_paddr",   64'(apb.paddr),   64'h1040);
    checkOutput("wr_c3_pwrite",  64'(apb.pwrite),  64'd1);
    checkOutput("wr_c3_pwdata",  64'(apb.pwdata),  64'hDEAD_BEEF);
    checkOutput("wr_c3_rsp",     64'(rspValid),    64'd0);
    tick();
    checkOutput("wr_c4_rsp",     64'(rspValid),    64'd1);
    checkOutput("wr_c4_err",     64'(rspErr),      64'd0);
    checkOutput("wr_c4_rdata",   64'(rspRdata),    64'd0);
    checkOutput("wr_c4_to",      64'(rspTimeout),  64'd0);
    checkOutput("wr_c4_psel",    64'(apb.psel),    64'd0);
    checkOutput("wr_c4_penable", 64'(apb.penable), 64'd0);
    rspReady = 1'b1;
    tick();
    rspReady = 1'b0;
    checkOutput("wr_c5_rsp",     64'(rspValid),    64'd0);
    checkOutput("wr_c5_busy",    64'(busy),        64'd0);

    // Read with 3 wait states: ACCESS cycles 3..6, pready high in cycle 6
    $display("[TB] read with wait states");
    preadyDrv       = 1'b0;
    rdataOverrideEn = 1'b1;
    rdataOverride   = 32'h0000_00A5;
    applyStimulus(1'b0, 16'h2010, 32'h0);
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("rd_ws%0d_psel", i),    64'(apb.psel),    64'd1);
      checkOutput($sformatf("rd_ws%0d_penable", i), 64'(apb.penable), 64'd1);
      checkOutput($sformatf("rd_ws%0d_paddr", i),   64'(apb.paddr),   64'h2010);
      checkOutput($sformatf("rd_ws%0d_rsp", i),     64'(rspValid),    64'd0);
      tick();
    end
    preadyDrv = 1'b1;
    checkOutput("rd_c6_psel",  64'(apb.psel), 64'd1);
    checkOutput("rd_c6_rsp",   64'(rspValid), 64'd0);
    tick();
    checkOutput("rd_c7_rsp",   64'(rspValid), 64'd1);
    checkOutput("rd_c7_rdata", 64'(rspRdata), 64'h0000_00A5);
    checkOutput("rd_c7_err",   64'(rspErr),   64'd0);
    rspReady = 1'b1;
    tick();
    rspReady        = 1'b0;
    rdataOverrideEn = 1'b0;

    // Slave error followed by a normal read
    $display("[TB] slave error");
    applyStimulus(1'b1, 16'h3000, 32'h0000_1234);
    applyStimulus(1'b0, 16'h3004, 32'h0);
    waitRsp("slverr", 20);
    checkOutput("slverr_err",   64'(rspErr),     64'd1);
    checkOutput("slverr_to",    64'(rspTimeout), 64'd0);
    checkOutput("slverr_rdata", 64'(rspRdata),   64'd0);
    rspReady = 1'b1;
    tick();
    rspReady = 1'b0;
    waitRsp("post_err", 20);
    checkOutput("post_err_err",   64'(rspErr),   64'd0);
    checkOutput("post_err_rdata", 64'(rspRdata), 64'hC0DE_3004);
    rspReady = 1'b1;
    tick();
    rspReady = 1'b0;

    // Back-pressure: 1 in flight + 4 queued fills the block
    $display("[TB] back-pressure");
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("bp_ready%0d", i), 64'(cmdReady), 64'd1);
      applyStimulus(1'b0, AW'(16'h1100 + i * 16'h0100), 32'h0);
    end
    checkOutput("bp_full_ready", 64'(cmdReady), 64'd0);
    checkOutput("bp_full_busy",  64'(busy),     64'd1);
    checkOutput("bp_full_rsp",   64'(rspValid), 64'd1);
    cmdValid = 1'b1;
    cmdWrite = 1'b0;
    cmdAddr  = 16'h1F00;
    tick();
    tick();
    checkOutput("bp_still_full", 64'(cmdReady), 64'd0);
    cmdValid = 1'b0;
    rspReady = 1'b1;
    for (int i = 0; i < 5; i++) begin
      waitRsp($sformatf("bp%0d", i), 20);
      checkOutput($sformatf("bp_rdata%0d", i), 64'(rspRdata),
                  64'(32'hC0DE_1100 + i * 32'h0100));
      tick();
    end
    extra = 0;
    repeat (12) begin
      tick();
      if (rspValid) extra++;
    end
    checkOutput("bp_no_extra_rsp", 64'(extra), 64'd0);
    checkOutput("bp_drained_busy", 64'(busy),  64'd0);
    rspReady = 1'b0;

    // Timeout: 8 ACCESS cycles (3..10), response in cycle 11
    $display("[TB] timeout");
    preadyDrv = 1'b0;
    applyStimulus(1'b1, 16'h4000, 32'h0000_0055);
    tick();
    tick();
    for (int i = 0; i < 8; i++) begin
      if (i == 7) begin
        checkOutput("to_last_psel", 64'(apb.psel), 64'd1);
        checkOutput("to_last_rsp",  64'(rspValid), 64'd0);
      end
      tick();
    end
    checkOutput("to_rsp",     64'(rspValid),    64'd1);
    checkOutput("to_flag",    64'(rspTimeout),  64'd1);
    checkOutput("to_err",     64'(rspErr),      64'd1);
    checkOutput("to_rdata",   64'(rspRdata),    64'd0);
    checkOutput("to_psel",    64'(apb.psel),    64'd0);
    checkOutput("to_penable", 64'(apb.penable), 64'd0);
    rspReady = 1'b1;
    tick();
    rspReady = 1'b0;

    // Reset during ACCESS with a second command still queued
    $display("[TB] reset mid-transfer");
    applyStimulus(1'b0, 16'h4004, 32'h0);
    applyStimulus(1'b1, 16'h4008, 32'h0000_0077);
    tick();
    checkOutput("rstx_access", 64'(apb.penable), 64'd1);
    rst = 1'b1;
    tick();
    checkOutput("rstx_psel",    64'(apb.psel),    64'd0);
    checkOutput("rstx_penable", 64'(apb.penable), 64'd0);
    checkOutput("rstx_busy",    64'(busy),        64'd0);
    checkOutput("rstx_rsp",     64'(rspValid),    64'd0);
    checkOutput("rstx_ready",   64'(cmdReady),    64'd1);
    checkOutput("rstx_paddr",   64'(apb.paddr),   64'd0);
    rst       = 1'b0;
    preadyDrv = 1'b1;
    rspReady  = 1'b1;
    extra     = 0;
    repeat (15) begin
      tick();
      if (rspValid) extra++;
    end
    checkOutput("rstx_no_rsp", 64'(extra), 64'd0);
    checkOutput("rstx_idle",   64'(busy),  64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
